// File: rtl/fetch_prefetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response, execute-side
// redirect/halt, and the downstream valid/ready instruction handoff.
//   master : used by fetch_prefetch_unit (drives imem_req/addr, out_*, halted)
//   slave  : used by the environment (memory, execute stage, decode)
interface fetch_prefetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic        halted;

  modport master (
    output imem_req, imem_addr, out_valid, out_inst, out_pc, out_pc4, halted,
    input  imem_valid, imem_rdata, redirect, redirect_pc, halt, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_inst, out_pc, out_pc4, halted,
    output imem_valid, imem_rdata, redirect, redirect_pc, halt, out_ready
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage. Owns the fetch PC, issues one request at a time to
// instruction memory, buffers returned words in a small prefetch queue and
// hands {inst, pc, pc+4} downstream over valid/ready. Accepts redirects
// (flush) and an ebreak halt from execute.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   fetch_io : fetch_prefetch_unit_if.master (imem_*, redirect*, halt, out_*, halted)
// Build option:
//   FETCH_BYPASS_EN : when defined, a response arriving while the queue is empty
//                     and not being flushed drives out_* in the same cycle.
module fetch_prefetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_prefetch_unit_if.master fetch_io
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StWait, StDrain, StHalted} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       addr_q, addr_d;
  logic              req_q, req_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [31:0]       inst_mem_q [QUEUE_DEPTH];
  logic [31:0]       pc_mem_q   [QUEUE_DEPTH];

  logic        flush;
  logic        halt_go;
  logic        resp_take;
  logic        head_valid;
  logic        byp_valid;
  logic        push;
  logic        pop;
  logic [31:0] redirect_pc_al;

  always_comb begin
    flush          = fetch_io.redirect && (state_q != StHalted);
    // Redirect wins over a simultaneous halt.
    halt_go        = fetch_io.halt && !fetch_io.redirect && (state_q != StHalted);
    redirect_pc_al = {fetch_io.redirect_pc[31:2], 2'b00};
    resp_take      = (state_q == StWait) && fetch_io.imem_valid;
    head_valid     = (count_q != '0);
`ifdef FETCH_BYPASS_EN
    byp_valid      = resp_take && (count_q == '0) && !flush && !halt_go;
`else
    byp_valid      = 1'b0;
`endif
    pop            = head_valid && fetch_io.out_ready;
    // A bypassed word that is accepted immediately never enters the queue.
    push           = resp_take && !(byp_valid && fetch_io.out_ready);
  end

  // Output path
  always_comb begin
    fetch_io.imem_req  = req_q;
    fetch_io.imem_addr = addr_q;
    fetch_io.halted    = (state_q == StHalted);
    fetch_io.out_valid = head_valid || byp_valid;
    if (byp_valid) begin
      fetch_io.out_inst = fetch_io.imem_rdata;
      fetch_io.out_pc   = addr_q;
    end else begin
      fetch_io.out_inst = inst_mem_q[rd_ptr_q];
      fetch_io.out_pc   = pc_mem_q[rd_ptr_q];
    end
    fetch_io.out_pc4 = fetch_io.out_pc + 32'd4;
  end

  // Fetch FSM next state
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    req_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush) begin
          fetch_pc_d = redirect_pc_al;
        end else if (halt_go) begin
          state_d = StHalted;
        end else if (32'(count_q) < QUEUE_DEPTH) begin
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
          state_d = StWait;
        end
      end
      StWait: begin
        if (flush) begin
          fetch_pc_d = redirect_pc_al;
          // A response landing with the redirect is already dropped; no drain needed.
          state_d    = fetch_io.imem_valid ? StIdle : StDrain;
        end else if (halt_go) begin
          state_d = StHalted;
        end else if (fetch_io.imem_valid) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = StIdle;
        end
      end
      StDrain: begin
        if (flush) begin
          fetch_pc_d = redirect_pc_al;
          state_d    = fetch_io.imem_valid ? StIdle : StDrain;
        end else if (halt_go) begin
          state_d = StHalted;
        end else if (fetch_io.imem_valid) begin
          state_d = StIdle;
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: state_d = StIdle;
    endcase
  end

  // Queue pointer/count next state
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush || halt_go) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage needs no reset; count_q qualifies every read.
  always_ff @(posedge clk) begin
    if (!rst && push && !flush && !halt_go) begin
      inst_mem_q[wr_ptr_q] <= fetch_io.imem_rdata;
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a simple latency-programmable
// instruction memory. Inputs change just after the falling edge; outputs are
// sampled 1 ns later, well before the next rising edge.
module tb_fetch_prefetch_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_prefetch_unit_if bus ();

  fetch_prefetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_io (bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Controls applied at the next falling edge
  logic        rst_v   = 1'b1;
  logic        rdy_v   = 1'b0;
  logic        redir_v = 1'b0;
  logic [31:0] rpc_v   = '0;
  logic        halt_v  = 1'b0;

  // Memory model
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;

  // Logs
  logic [31:0] req_log [$];
  logic [31:0] opc_log [$];
  logic [31:0] oin_log [$];
  logic [31:0] op4_log [$];
  logic        seen_valid;
  logic        ov_at_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    rst             = rst_v;
    bus.out_ready   = rdy_v;
    bus.redirect    = redir_v;
    bus.redirect_pc = rpc_v;
    bus.halt        = halt_v;
    bus.imem_valid  = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        bus.imem_valid = 1'b1;
        bus.imem_rdata = mem_word(mem_addr);
      end
    end
    #1;
    if (bus.imem_valid && !seen_valid) begin
      seen_valid  = 1'b1;
      ov_at_valid = bus.out_valid;
    end
    if (bus.imem_req) begin
      req_log.push_back(bus.imem_addr);
      mem_addr = bus.imem_addr;
      mem_cnt  = mem_lat;
    end
    if (bus.out_valid && bus.out_ready) begin
      opc_log.push_back(bus.out_pc);
      oin_log.push_back(bus.out_inst);
      op4_log.push_back(bus.out_pc4);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rst_v = 1'b1; rdy_v = 1'b0; redir_v = 1'b0; halt_v = 1'b0;
    run(3);
    rst_v = 1'b0;
    mem_cnt = 0;
    req_log.delete(); opc_log.delete(); oin_log.delete(); op4_log.delete();
    seen_valid = 1'b0;
  endtask

  initial begin
    bus.imem_valid = 1'b0; bus.imem_rdata = '0; bus.out_ready = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.halt = 1'b0;
    rst = 1'b1;
    seen_valid = 1'b0; ov_at_valid = 1'b0;

    // 1: reset state, then streaming fetch with ready=1
    mem_lat = 1;
    do_reset();
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_halted", 32'(bus.halted), 32'd0);
    check_eq("rst_imem_req", 32'(bus.imem_req), 32'd0);
    rdy_v = 1'b1;
    run(14);
    check_eq("t1_req0", req_log[0], 32'h0);
    check_eq("t1_req1", req_log[1], 32'h4);
    check_eq("t1_req2", req_log[2], 32'h8);
    check_eq("t1_nout", 32'(opc_log.size() >= 3), 32'd1);
    check_eq("t1_pc0", opc_log[0], 32'h0);
    check_eq("t1_pc1", opc_log[1], 32'h4);
    check_eq("t1_pc2", opc_log[2], 32'h8);
    check_eq("t1_in0", oin_log[0], 32'h1357_9BDF);
    check_eq("t1_in1", oin_log[1], 32'h1357_9BDB);
    check_eq("t1_in2", oin_log[2], 32'h1357_9BD7);
    check_eq("t1_p40", op4_log[0], 32'h4);
    check_eq("t1_p41", op4_log[1], 32'h8);
    check_eq("t1_p42", op4_log[2], 32'hC);

    // 2: backpressure fills the queue, one pop frees one slot
    do_reset();
    rdy_v = 1'b0;
    run(20);
    check_eq("t2_nreq_full", 32'(req_log.size()), 32'd2);
    check_eq("t2_out_valid", 32'(bus.out_valid), 32'd1);
    check_eq("t2_head_pc", bus.out_pc, 32'h0);
    rdy_v = 1'b1;
    cyc();
    rdy_v = 1'b0;
    run(10);
    check_eq("t2_npop", 32'(opc_log.size()), 32'd1);
    check_eq("t2_pop_pc", opc_log[0], 32'h0);
    check_eq("t2_nreq", 32'(req_log.size()), 32'd3);
    check_eq("t2_req2", req_log[2], 32'h8);
    check_eq("t2_head_pc2", bus.out_pc, 32'h4);

    // 3: redirect while waiting discards the in-flight response
    mem_lat = 3;
    do_reset();
    rdy_v = 1'b1;
    begin
      int k;
      k = 0;
      while (req_log.size() == 0 && k < 20) begin
        cyc();
        k++;
      end
    end
    check_eq("t3_first_req", 32'(req_log.size()), 32'd1);
    redir_v = 1'b1; rpc_v = 32'h0000_0103;
    cyc();
    redir_v = 1'b0;
    run(20);
    check_eq("t3_req1", req_log[1], 32'h100);
    check_eq("t3_out_pc0", opc_log[0], 32'h100);
    check_eq("t3_out_in0", oin_log[0], 32'h1357_9ADF);

    // 4: halt with a full queue, then reset restarts fetch
    mem_lat = 1;
    do_reset();
    rdy_v = 1'b0;
    run(12);
    check_eq("t4_full_valid", 32'(bus.out_valid), 32'd1);
    halt_v = 1'b1;
    cyc();
    halt_v = 1'b0;
    cyc();
    check_eq("t4_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("t4_halted", 32'(bus.halted), 32'd1);
    begin
      int nreq;
      nreq = req_log.size();
      rdy_v = 1'b1;
      run(10);
      check_eq("t4_no_req", 32'(req_log.size()), 32'(nreq));
      check_eq("t4_still_halted", 32'(bus.halted), 32'd1);
    end
    do_reset();
    rdy_v = 1'b1;
    run(8);
    check_eq("t4_restart_req", req_log[0], 32'h0);
    check_eq("t4_restart_pc", opc_log[0], 32'h0);
    check_eq("t4_unhalted", 32'(bus.halted), 32'd0);

    // 5a: redirect and halt together -> redirect wins
    do_reset();
    rdy_v = 1'b1;
    redir_v = 1'b1; halt_v = 1'b1; rpc_v = 32'h0000_0040;
    cyc();
    redir_v = 1'b0; halt_v = 1'b0;
    run(8);
    check_eq("t5_not_halted", 32'(bus.halted), 32'd0);
    check_eq("t5_req0", req_log[0], 32'h40);
    check_eq("t5_pc0", opc_log[0], 32'h40);

    // 5b: fetch PC wraps from FFFF_FFFC to 0
    do_reset();
    rdy_v = 1'b1;
    redir_v = 1'b1; rpc_v = 32'hFFFF_FFFE;
    cyc();
    redir_v = 1'b0;
    run(10);
    check_eq("t5_wrap_req0", req_log[0], 32'hFFFF_FFFC);
    check_eq("t5_wrap_req1", req_log[1], 32'h0);
    check_eq("t5_wrap_pc0", opc_log[0], 32'hFFFF_FFFC);
    check_eq("t5_wrap_p40", op4_log[0], 32'h0);
    check_eq("t5_wrap_pc1", opc_log[1], 32'h0);

    // 6: first-response latency, with or without bypass
    do_reset();
    rdy_v = 1'b1;
    begin
      int k;
      k = 0;
      while (!seen_valid && k < 20) begin
        cyc();
        k++;
      end
    end
    check_eq("t6_seen_valid", 32'(seen_valid), 32'd1);
`ifdef FETCH_BYPASS_EN
    check_eq("t6_ov_cycle_n", 32'(ov_at_valid), 32'd1);
    cyc();
    check_eq("t6_ov_cycle_n1", 32'(bus.out_valid), 32'd0);
`else
    check_eq("t6_ov_cycle_n", 32'(ov_at_valid), 32'd0);
    cyc();
    check_eq("t6_ov_cycle_n1", 32'(bus.out_valid), 32'd1);
`endif
    run(3);
    check_eq("t6_pc0", opc_log[0], 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
